// File: rtl/conf_arb_pkg.sv
// Shared types and constants for the configuration-register port arbiter.
package conf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

  // Pointer holds the most recent winner; starting at DBG lets CPU win the first tie.
  localparam logic RR_PTR_RST = M_DBG;

endpackage

// File: rtl/confreg_arbiter_rr_arb2.sv
// Two-input round-robin selector: a lone requester wins outright, a tie goes
// to whichever requester was not granted most recently.
module rr_arb2
  import conf_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q;
  logic last_d;

  // Winner selection and pointer next-state.
  always_comb begin
    grant  = '0;
    last_d = last_q;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_q == M_CPU) ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
    if (advance && (grant != '0)) begin
      last_d = grant[1] ? M_DBG : M_CPU;
    end
  end

  // Most-recent-winner pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= RR_PTR_RST;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/confreg_arbiter.sv
// Shares the single confreg access port between the CPU data path (m0) and
// the debug/host path (m1): grant in IDLE, one conf_en strobe in ISSUE, held
// response in RESP until the winner accepts it.
module confreg_arbiter
  import conf_arb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          m0_req,
  input  logic [3:0]    m0_wen,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m0_rready,

  input  logic          m1_req,
  input  logic [3:0]    m1_wen,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  input  logic          m1_rready,

  output logic          conf_en,
  output logic [3:0]    conf_wen,
  output logic [AW-1:0] conf_addr,
  output logic [DW-1:0] conf_wdata,
  input  logic [DW-1:0] conf_rdata
);

  arb_state_t    state_q;
  logic          conf_en_q;
  logic [3:0]    conf_wen_q;
  logic [AW-1:0] conf_addr_q;
  logic [DW-1:0] conf_wdata_q;
  logic          id_q;
  logic [1:0]    rvalid_q;
  logic [DW-1:0] rdata_q;

  logic [1:0]    arb_req;
  logic [1:0]    arb_grant;
  logic          arb_advance;
  logic [3:0]    sel_wen;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          rsp_done;

  // Requests are only visible to the selector in IDLE and out of reset.
  assign arb_req     = {m1_req, m0_req} & {2{(state_q == IDLE) && !reset}};
  assign arb_advance = (state_q == IDLE);

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (arb_advance),
    .grant   (arb_grant)
  );

  // Route the winning requester's fields toward the capture registers.
  always_comb begin
    sel_wen   = m0_wen;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (arb_grant[1]) begin
      sel_wen   = m1_wen;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  assign rsp_done = (rvalid_q[0] & m0_rready) | (rvalid_q[1] & m1_rready);

  // Transaction FSM; the conf_* registers double as the request capture, so
  // they load at grant, drive the bus for the ISSUE cycle only, then clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      conf_en_q    <= 1'b0;
      conf_wen_q   <= '0;
      conf_addr_q  <= '0;
      conf_wdata_q <= '0;
      id_q         <= M_CPU;
      rvalid_q     <= '0;
      rdata_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arb_grant != '0) begin
            conf_en_q    <= 1'b1;
            conf_wen_q   <= sel_wen;
            conf_addr_q  <= sel_addr;
            conf_wdata_q <= sel_wdata;
            id_q         <= arb_grant[1] ? M_DBG : M_CPU;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          conf_en_q    <= 1'b0;
          conf_wen_q   <= '0;
          conf_addr_q  <= '0;
          conf_wdata_q <= '0;
          rdata_q      <= (conf_wen_q == '0) ? conf_rdata : '0;
          rvalid_q     <= (id_q == M_DBG) ? 2'b10 : 2'b01;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m0_gnt     = arb_grant[0];
  assign m1_gnt     = arb_grant[1];
  assign m0_rvalid  = rvalid_q[0];
  assign m1_rvalid  = rvalid_q[1];
  assign m0_rdata   = rvalid_q[0] ? rdata_q : '0;
  assign m1_rdata   = rvalid_q[1] ? rdata_q : '0;
  assign conf_en    = conf_en_q;
  assign conf_wen   = conf_wen_q;
  assign conf_addr  = conf_addr_q;
  assign conf_wdata = conf_wdata_q;

endmodule

// File: tb/tb_confreg_arbiter.sv
// Scoreboard bench for confreg_arbiter: directed transactions push expected
// grants, bus strobes and responses; a negedge monitor pops and compares.
module tb_confreg_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m1_req;
  logic [3:0]    m0_wen, m1_wen;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt;
  logic          m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_rready, m1_rready;
  logic          conf_en;
  logic [3:0]    conf_wen;
  logic [AW-1:0] conf_addr;
  logic [DW-1:0] conf_wdata;
  logic [DW-1:0] conf_rdata;

  always #5 clk = ~clk;

  confreg_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rready(m0_rready),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rready(m1_rready),
    .conf_en(conf_en), .conf_wen(conf_wen), .conf_addr(conf_addr),
    .conf_wdata(conf_wdata), .conf_rdata(conf_rdata)
  );

  // Tiny confreg model: 16-bit led register at 0xf000, word scratch elsewhere.
  logic [15:0] led_q = '0;
  logic [31:0] mem [16] = '{default: '0};
  assign conf_rdata = (conf_addr == 32'hf000) ? {16'h0, led_q} : mem[conf_addr[5:2]];

  always @(posedge clk) begin
    if (conf_en && conf_wen != 4'h0) begin
      if (conf_addr == 32'hf000) begin
        if (conf_wen[0]) led_q[7:0]  <= conf_wdata[7:0];
        if (conf_wen[1]) led_q[15:8] <= conf_wdata[15:8];
      end else begin
        for (int b = 0; b < 4; b++)
          if (conf_wen[b]) mem[conf_addr[5:2]][b*8 +: 8] <= conf_wdata[b*8 +: 8];
      end
    end
  end

  typedef struct { logic [3:0] wen; logic [31:0] addr; logic [31:0] wdata; } bus_t;
  typedef struct { int id; logic [31:0] rdata; } rsp_t;

  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  int   exp_gnt[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard.
  int   last_gnt_cyc = -10;
  int   last_conf_cyc = -10;
  int   last_hs_cyc = -10;
  int   gnt_seen = 0;
  int   rsp_seen = 0;
  bit   prev_rv = 1'b0;
  bit   tie_mode = 1'b0;
  bus_t mon_b;
  rsp_t mon_r;
  int   mon_gid;

  always @(negedge clk) begin
    if (reset) begin
      prev_rv = 1'b0;
    end else begin
      if (m0_gnt || m1_gnt) begin
        mon_gid = m1_gnt ? 1 : 0;
        check("gnt_onehot", 64'(m0_gnt & m1_gnt), 64'd0);
        if (exp_gnt.size() == 0) check("gnt_unexpected", 64'(exp_gnt.size()), 64'd1);
        else check("gnt_id", 64'(mon_gid), 64'(exp_gnt.pop_front()));
        last_gnt_cyc = cyc;
        gnt_seen++;
      end
      if (conf_en) begin
        check("conf_lat", 64'(cyc), 64'(last_gnt_cyc + 1));
        if (tie_mode && last_conf_cyc >= 0)
          check("conf_period", 64'(cyc - last_conf_cyc), 64'd3);
        if (exp_bus.size() == 0) check("bus_unexpected", 64'(exp_bus.size()), 64'd1);
        else begin
          mon_b = exp_bus.pop_front();
          check("conf_wen", 64'(conf_wen), 64'(mon_b.wen));
          check("conf_addr", 64'(conf_addr), 64'(mon_b.addr));
          check("conf_wdata", 64'(conf_wdata), 64'(mon_b.wdata));
        end
        last_conf_cyc = cyc;
      end else begin
        check("conf_quiet", 64'(conf_addr | conf_wdata | 32'(conf_wen)), 64'd0);
      end
      if ((m0_rvalid || m1_rvalid) && !prev_rv)
        check("rsp_lat", 64'(cyc), 64'(last_conf_cyc + 1));
      if (m0_rvalid || m1_rvalid)
        check("rvalid_onehot", 64'(m0_rvalid & m1_rvalid), 64'd0);
      prev_rv = m0_rvalid || m1_rvalid;
      if ((m0_rvalid && m0_rready) || (m1_rvalid && m1_rready)) begin
        if (exp_rsp.size() == 0) check("rsp_unexpected", 64'(exp_rsp.size()), 64'd1);
        else begin
          mon_r = exp_rsp.pop_front();
          check("rsp_id", 64'(m1_rvalid ? 1 : 0), 64'(mon_r.id));
          check("rsp_rdata", 64'(m1_rvalid ? m1_rdata : m0_rdata), 64'(mon_r.rdata));
        end
        last_hs_cyc = cyc;
        rsp_seen++;
      end
    end
  end

  task automatic drive(input int id, input logic r, input logic [3:0] wen,
                       input logic [31:0] a, input logic [31:0] d);
    if (id == 0) begin
      m0_req = r; m0_wen = wen; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = r; m1_wen = wen; m1_addr = a; m1_wdata = d;
    end
  endtask

  task automatic expect_txn(input int id, input logic [3:0] wen, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] rd, input bit full);
    bus_t b;
    rsp_t r;
    exp_gnt.push_back(id);
    if (full) begin
      b.wen = wen; b.addr = a; b.wdata = d;
      exp_bus.push_back(b);
      r.id = id; r.rdata = rd;
      exp_rsp.push_back(r);
    end
  endtask

  task automatic wait_gnt(input int id);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = (id == 0) ? m0_gnt : m1_gnt;
    end
    check("gnt_wait", 64'(ok), 64'd1);
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 60 && rsp_seen < n; i++) @(posedge clk);
    check("rsp_count", 64'(rsp_seen), 64'(n));
  endtask

  task automatic wait_rvalid0();
    for (int i = 0; i < 20 && !m0_rvalid; i++) @(negedge clk);
    check("rvalid_wait", 64'(m0_rvalid), 64'd1);
  endtask

  // Full transaction from one requester: expectations, request, grant, release.
  task automatic issue(input int id, input logic [3:0] wen, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rd, input bit full);
    expect_txn(id, wen, a, d, rd, full);
    drive(id, 1'b1, wen, a, d);
    wait_gnt(id);
    @(posedge clk); #1;
    drive(id, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic clear_sb();
    exp_gnt.delete();
    exp_bus.delete();
    exp_rsp.delete();
  endtask

  int base;
  int g0;

  initial begin
    reset = 1'b1;
    m0_rready = 1'b1;
    m1_rready = 1'b1;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_gnt", 64'({m1_gnt, m0_gnt}), 64'd0);
    check("rst_rvalid", 64'({m1_rvalid, m0_rvalid}), 64'd0);
    check("rst_rdata", 64'(m0_rdata | m1_rdata), 64'd0);
    check("rst_conf_en", 64'(conf_en), 64'd0);
    check("rst_conf_bus", 64'(conf_addr | conf_wdata | 32'(conf_wen)), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // m0 write to led, read back; m1 read of an updated led value.
    issue(0, 4'hF, 32'hf000, 32'h0000_00A5, 32'h0, 1'b1);
    wait_rsp(1);
    issue(0, 4'h0, 32'hf000, 32'h0, 32'h0000_00A5, 1'b1);
    wait_rsp(2);
    issue(0, 4'h3, 32'hf000, 32'h0000_1234, 32'h0, 1'b1);
    wait_rsp(3);
    issue(1, 4'h0, 32'hf000, 32'h0, 32'h0000_1234, 1'b1);
    wait_rsp(4);

    // Both requesting continuously from reset: strict 0,1,0,1.
    @(posedge clk); #1;
    reset = 1'b1;
    clear_sb();
    base = rsp_seen;
    drive(0, 1'b1, 4'hF, 32'h10, 32'hCAFE_0000);
    drive(1, 1'b1, 4'h0, 32'hf000, 32'h0);
    for (int k = 0; k < 2; k++) begin
      expect_txn(0, 4'hF, 32'h10, 32'hCAFE_0000, 32'h0, 1'b1);
      expect_txn(1, 4'h0, 32'hf000, 32'h0, 32'h0000_1234, 1'b1);
    end
    tie_mode = 1'b1;
    last_conf_cyc = -1;
    @(negedge clk);
    check("rst_gnt_masked", 64'({m1_gnt, m0_gnt}), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    g0 = gnt_seen;
    for (int i = 0; i < 40 && gnt_seen < g0 + 4; i++) @(posedge clk);
    check("tie_gnt_count", 64'(gnt_seen - g0), 64'd4);
    #1;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
    wait_rsp(base + 4);
    tie_mode = 1'b0;

    // Backpressure on m0 while m1 waits.
    base = rsp_seen;
    m0_rready = 1'b0;
    issue(0, 4'h0, 32'hf000, 32'h0, 32'h0000_1234, 1'b1);
    expect_txn(1, 4'hF, 32'h14, 32'h0000_0055, 32'h0, 1'b1);
    drive(1, 1'b1, 4'hF, 32'h14, 32'h0000_0055);
    wait_rvalid0();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rvalid", 64'(m0_rvalid), 64'd1);
      check("bp_rdata", 64'(m0_rdata), 64'h1234);
      check("bp_m1_gnt", 64'(m1_gnt), 64'd0);
    end
    @(posedge clk); #1 m0_rready = 1'b1;
    wait_gnt(1);
    check("bp_m1_after_hs", 64'(cyc), 64'(last_hs_cyc + 1));
    @(posedge clk); #1;
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
    wait_rsp(base + 2);
    issue(1, 4'h0, 32'h14, 32'h0, 32'h0000_0055, 1'b1);
    wait_rsp(base + 3);

    // Reset during ISSUE.
    issue(0, 4'hF, 32'h18, 32'h77, 32'h0, 1'b0);
    check("pre_rst_conf_en", 64'(conf_en), 64'd1);
    reset = 1'b1;
    #1;
    check("rst_issue_conf_en", 64'(conf_en), 64'd0);
    check("rst_issue_conf_addr", 64'(conf_addr), 64'd0);
    clear_sb();
    @(posedge clk); #1 reset = 1'b0;

    // Reset during RESP, then the first tie goes to m0.
    m0_rready = 1'b0;
    issue(0, 4'h0, 32'hf000, 32'h0, 32'h0000_1234, 1'b1);
    wait_rvalid0();
    reset = 1'b1;
    #1;
    check("rst_resp_rvalid", 64'(m0_rvalid), 64'd0);
    check("rst_resp_rdata", 64'(m0_rdata), 64'd0);
    clear_sb();
    m0_rready = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    base = rsp_seen;
    expect_txn(0, 4'h0, 32'h10, 32'h0, 32'hCAFE_0000, 1'b1);
    drive(0, 1'b1, 4'h0, 32'h10, 32'h0);
    drive(1, 1'b1, 4'h0, 32'hf000, 32'h0);
    wait_gnt(0);
    check("tie_post_rst_m1_gnt", 64'(m1_gnt), 64'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
    wait_rsp(base + 1);

    // Idle bus.
    g0 = gnt_seen;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_conf_en", 64'(conf_en), 64'd0);
      check("idle_conf_addr", 64'(conf_addr), 64'd0);
      check("idle_conf_wdata", 64'(conf_wdata), 64'd0);
    end
    check("idle_no_gnt", 64'(gnt_seen - g0), 64'd0);

    check("sb_gnt_empty", 64'(exp_gnt.size()), 64'd0);
    check("sb_bus_empty", 64'(exp_bus.size()), 64'd0);
    check("sb_rsp_empty", 64'(exp_rsp.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 64'd0, 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/confreg_arbiter.md
# confreg_arbiter

Two-requester arbiter sharing the single configuration-register port (conf_en/conf_wen/conf_addr/conf_wdata/conf_rdata) between the CPU data path (requester 0) and the debug/host access path (requester 1). Round-robin grant, one outstanding transaction, registered request capture and registered response with valid/ready handshake. Sits between the requesters and the confreg block in the SoC peripheral subsystem.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (XLEN)

Ports (N = 0, 1):
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- mN_req  in  1  request valid; fields below held stable while req=1 and gnt=0
- mN_wen  in  4  byte write enables; 0 = read
- mN_addr  in  AW  target address
- mN_wdata  in  DW  write data
- mN_gnt  out  1  one-cycle pulse: request accepted, fields captured this cycle
- mN_rvalid  out  1  response valid (read data, or write completion)
- mN_rdata  out  DW  read data; 0 for writes
- mN_rready  in  1  requester accepts response
- conf_en  out  1  confreg access strobe
- conf_wen  out  4  confreg byte write enables
- conf_addr  out  AW  confreg address
- conf_wdata  out  DW  confreg write data
- conf_rdata  in  DW  confreg read data, combinational from conf_addr in the conf_en cycle

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any mN_req, select winner, pulse mN_gnt, capture wen/addr/wdata and winner id into registers -> ISSUE. No req: stay.
- Selection: single req wins outright; both asserted -> requester not granted most recently (rr pointer). Pointer updates to winner on every grant; reset value points so requester 0 wins the first tie.
- ISSUE: conf_en=1 for exactly this cycle, conf_wen/addr/wdata from capture registers; rdata register loads conf_rdata if captured wen==0, else 0 -> RESP.
- RESP: winner's mN_rvalid=1, mN_rdata=rdata register, both held until mN_rready=1; on rvalid&rready -> IDLE. Loser's rvalid stays 0.
- Requests arriving in ISSUE/RESP are not granted; they wait (req held) until IDLE.
- conf_wen/addr/wdata are 0 whenever conf_en=0 (no stale address on the bus).
- mN_rready while mN_rvalid=0 ignored.

## Timing
- Reset (asynchronous, any state, including mid-ISSUE or mid-RESP): state IDLE, all gnt/rvalid/conf_en = 0, all data/addr outputs 0, rr pointer favours requester 0; in-flight transaction discarded.
- Grant latency: req high in IDLE -> gnt same cycle (combinational from req, qualified by state).
- conf_en asserted the cycle after gnt; rvalid asserted the cycle after conf_en.
- Minimum transaction: 3 cycles (IDLE gnt, ISSUE, RESP with rready=1); back-to-back throughput one access per 3 cycles.
- Tie under continuous requests from both: strict alternation 0,1,0,1...
- Backpressure: rready low holds RESP indefinitely; rvalid/rdata stable throughout.
- Exactly one conf_en pulse per gnt pulse; no conf_en without a prior gnt.

## Structure
- Shared package conf_arb_pkg: state enum (IDLE, ISSUE, RESP), requester-id constants (M_CPU=0, M_DBG=1), reset value of rr pointer.
- One sub-module: rr_arb2 — two-input round-robin selector with pointer register (inputs req[1:0], advance; outputs one-hot grant). FSM, capture and response registers remain in confreg_arbiter.

## Test plan
- Reset then m0 write wen=4'hF addr=32'hf000 wdata=32'h0000_00A5 -> m0_gnt cycle 0, conf_en cycle 1 with those values, m0_rvalid cycle 2 rdata=0; led register reads back 16'h00A5.
- m1 read addr=32'hf000 with conf_rdata=32'h1234 -> m1_rvalid with m1_rdata=32'h1234, m0_rvalid never asserted.
- Both req continuously from reset, rready=1 -> grant order 0,1,0,1; conf_en every 3rd cycle.
- m0 read with m0_rready low 5 cycles -> rvalid/rdata stable 5 cycles, m1 req ignored until handshake, then m1 granted in next IDLE.
- Assert reset during ISSUE and during RESP -> conf_en and rvalid drop immediately; after release, tie goes to requester 0.
- Idle bus check: no req for 10 cycles -> conf_en=0, conf_addr=0, conf_wdata=0 throughout.
